// File: rtl/run_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | run_sequencer : reset-hold / run / halt-or-timeout sequencer for a core  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module run_sequencer #(
  parameter int D         = 12,
  parameter int HALT_ADDR = 128,
  parameter int RST_CYC   = 2,
  parameter int MAX_CYC   = 1000,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [1:0]    prog_sel,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_rst,
  output logic          core_en,
  output logic [1:0]    start_sel,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int            HW        = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYC - 1);
  localparam logic [CW-1:0] CYC_LIMIT = CW'(MAX_CYC);
  localparam logic [D-1:0]  HALT_PC   = D'(HALT_ADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_RUN   = 3'd2,
    S_FIN   = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic [1:0]    start_sel_q, start_sel_d;
  logic          core_en_q, core_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycles_d    = cycles_q;
    start_sel_d = start_sel_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d     = S_HOLD;
          start_sel_d = prog_sel;
          cycles_d    = '0;
          hold_cnt_d  = '0;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // the halting cycle is itself counted; halt beats the limit on a tie
        cycles_d = cycles_q + 1'b1;
        if (prog_ctr == HALT_PC) begin
          state_d = S_FIN;
        end else if (cycles_d == CYC_LIMIT) begin
          state_d = S_ABORT;
        end
      end
      S_FIN, S_ABORT: begin
        if (!req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are registered from the next state so they line up with it
    core_en_d = (state_d == S_RUN);
    busy_d    = (state_d == S_HOLD) || (state_d == S_RUN);
    done_d    = (state_d == S_FIN) || (state_d == S_ABORT);
    timeout_d = (state_d == S_ABORT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      cycles_q    <= '0;
      start_sel_q <= 2'd0;
      core_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycles_q    <= cycles_d;
      start_sel_q <= start_sel_d;
      core_en_q   <= core_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign core_rst  = reset | (state_q == S_HOLD);
  assign core_en   = core_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycles    = cycles_q;
  assign start_sel = start_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_run_sequencer : table-driven self-checking bench for run_sequencer    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_run_sequencer;

  logic        clk;
  logic        reset;
  logic        req;
  logic [1:0]  prog_sel;
  logic [11:0] prog_ctr;
  logic        core_rst;
  logic        core_en;
  logic [1:0]  start_sel;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycles;

  run_sequencer #(
    .D(12), .HALT_ADDR(128), .RST_CYC(2), .MAX_CYC(20), .CW(16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
    .prog_ctr(prog_ctr), .core_rst(core_rst), .core_en(core_en),
    .start_sel(start_sel), .busy(busy), .done(done), .timeout(timeout),
    .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_IDLE = 0;
  localparam int K_HOLD = 1;
  localparam int K_RUN  = 2;
  localparam int K_FIN  = 3;
  localparam int K_ABT  = 4;

  // one row: inputs held across an edge, outputs expected just after it
  typedef struct {
    logic        rst;
    logic        rq;
    logic [1:0]  sel;
    logic [11:0] pc;
    logic        e_rst;
    logic        e_en;
    logic        e_busy;
    logic        e_done;
    logic        e_to;
    logic [15:0] e_cyc;
    logic [1:0]  e_sel;
  } vec_t;

  vec_t tbl[$];
  int   total  = 0;
  int   passed = 0;

  function automatic void add(input logic rst, input logic rq, input logic [1:0] sel,
                              input logic [11:0] pc, input int kind,
                              input int cyc, input logic [1:0] esel);
    vec_t v;
    v.rst    = rst;
    v.rq     = rq;
    v.sel    = sel;
    v.pc     = pc;
    v.e_rst  = rst | (kind == K_HOLD);
    v.e_en   = (kind == K_RUN);
    v.e_busy = (kind == K_HOLD) || (kind == K_RUN);
    v.e_done = (kind == K_FIN) || (kind == K_ABT);
    v.e_to   = (kind == K_ABT);
    v.e_cyc  = 16'(cyc);
    v.e_sel  = esel;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    add(1, 0, 0, 0, K_IDLE, 0, 0);
    add(0, 0, 0, 0, K_IDLE, 0, 0);
    // normal run, program 2, halt on 10th RUN cycle
    add(0, 1, 2, 0, K_HOLD, 0, 2);
    add(0, 1, 2, 0, K_HOLD, 0, 2);
    add(0, 1, 2, 0, K_RUN,  0, 2);
    for (int j = 1; j <= 9; j++) add(0, 1, 2, 12'(j), K_RUN, j, 2);
    add(0, 1, 2, 128, K_FIN, 10, 2);
    // req held: done stays, no restart
    for (int j = 0; j < 5; j++) add(0, 1, 0, 0, K_FIN, 10, 2);
    add(0, 0, 0, 0, K_IDLE, 10, 2);
    // restart with program 1, runs into the 20-cycle limit
    add(0, 1, 1, 0, K_HOLD, 0, 1);
    add(0, 1, 1, 0, K_HOLD, 0, 1);
    add(0, 1, 1, 0, K_RUN,  0, 1);
    for (int j = 1; j <= 19; j++) add(0, 1, 1, 12'(j), K_RUN, j, 1);
    add(0, 1, 1, 0, K_ABT, 20, 1);
    add(0, 1, 1, 0, K_ABT, 20, 1);
    add(0, 0, 1, 0, K_IDLE, 20, 1);
    // halt exactly on the limit cycle
    add(0, 1, 3, 0, K_HOLD, 0, 3);
    add(0, 1, 3, 0, K_HOLD, 0, 3);
    add(0, 1, 3, 0, K_RUN,  0, 3);
    for (int j = 1; j <= 19; j++) add(0, 1, 3, 12'(j + 300), K_RUN, j, 3);
    add(0, 1, 3, 128, K_FIN, 20, 3);
    add(0, 0, 3, 0, K_IDLE, 20, 3);
    // req/prog_sel noise during HOLD and RUN
    add(0, 1, 2, 0, K_HOLD, 0, 2);
    add(0, 0, 3, 0, K_HOLD, 0, 2);
    add(0, 1, 3, 0, K_RUN,  0, 2);
    for (int j = 1; j <= 4; j++) add(0, logic'(j % 2), 3, 12'(j), K_RUN, j, 2);
    add(0, 0, 3, 128, K_FIN, 5, 2);
    add(0, 0, 3, 0, K_IDLE, 5, 2);
    add(0, 0, 3, 0, K_IDLE, 5, 2);
    // reset during RUN cycle 7
    add(0, 1, 1, 0, K_HOLD, 0, 1);
    add(0, 1, 1, 0, K_HOLD, 0, 1);
    add(0, 1, 1, 0, K_RUN,  0, 1);
    for (int j = 1; j <= 6; j++) add(0, 1, 1, 12'(j), K_RUN, j, 1);
    add(1, 0, 1, 7, K_IDLE, 0, 0);
    add(0, 0, 0, 0, K_IDLE, 0, 0);

    reset    = 1'b1;
    req      = 1'b0;
    prog_sel = 2'd0;
    prog_ctr = 12'd0;

    for (int i = 0; i < tbl.size(); i++) begin
      reset    = tbl[i].rst;
      req      = tbl[i].rq;
      prog_sel = tbl[i].sel;
      prog_ctr = tbl[i].pc;
      tick();
      check("core_rst",  i, 16'(core_rst),  16'(tbl[i].e_rst));
      check("core_en",   i, 16'(core_en),   16'(tbl[i].e_en));
      check("busy",      i, 16'(busy),      16'(tbl[i].e_busy));
      check("done",      i, 16'(done),      16'(tbl[i].e_done));
      check("timeout",   i, 16'(timeout),   16'(tbl[i].e_to));
      check("cycles",    i, cycles,         tbl[i].e_cyc);
      check("start_sel", i, 16'(start_sel), 16'(tbl[i].e_sel));
    end

    // core_rst follows reset combinationally, before the edge is taken
    req      = 1'b1;
    prog_sel = 2'd2;
    prog_ctr = 12'd0;
    tick();
    tick();
    tick();
    tick();
    tick();
    check("seq_run_en",   900, 16'(core_en), 16'd1);
    check("seq_run_cyc",  900, cycles,       16'd2);
    check("seq_run_rst",  900, 16'(core_rst), 16'd0);
    reset = 1'b1;
    #1;
    check("seq_rst_comb", 901, 16'(core_rst), 16'd1);
    check("seq_en_held",  901, 16'(core_en),  16'd1);
    req = 1'b0;
    tick();
    check("seq_rst_en",   902, 16'(core_en), 16'd0);
    check("seq_rst_busy", 902, 16'(busy),    16'd0);
    check("seq_rst_cyc",  902, cycles,       16'd0);
    reset = 1'b0;
    tick();
    check("seq_rel_rst",  903, 16'(core_rst), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
